// File: rtl/cursor_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cursor_pkg
//  Description : Shared types and constants for the multi-cursor controller:
//                FSM state encoding, button bit positions inside each
//                cursor's 4-bit button group, and the default plot colours.
//  Revision    : 1.0 - initial release
// ============================================================================
package cursor_pkg;

  // Controller states; explicit width keeps the encoding stable across tools
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    ERASE = 3'd2,
    DRAW  = 3'd3,
    NEXT  = 3'd4
  } state_t;

  // Bit positions within one cursor's 4-bit (active-low) button group
  localparam int BTN_LEFT  = 3;
  localparam int BTN_UP    = 2;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_RIGHT = 0;

  // Default colours: cursor is red, background is black
  localparam logic [2:0] DEF_CUR_COLOUR = 3'b100;
  localparam logic [2:0] DEF_BG_COLOUR  = 3'b000;

endpackage
`default_nettype wire

// File: rtl/cursor_ctrl_multi_if.sv
`default_nettype none
// ============================================================================
//  Interface   : cursor_ctrl_multi_if
//  Description : Valid/ready plot bus between the cursor controller (master)
//                and the frame-buffer writer (slave). A pixel is transferred
//                on a clock edge where plot_valid and plot_ready are both high.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cursor_ctrl_multi_if #(
  parameter int XW = 8,
  parameter int YW = 7
);

  logic          plot_valid;
  logic          plot_ready;
  logic [XW-1:0] plot_x;
  logic [YW-1:0] plot_y;
  logic [2:0]    plot_colour;

  modport master (
    output plot_valid,
    output plot_x,
    output plot_y,
    output plot_colour,
    input  plot_ready
  );

  modport slave (
    input  plot_valid,
    input  plot_x,
    input  plot_y,
    input  plot_colour,
    output plot_ready
  );

endinterface
`default_nettype wire

// File: rtl/cursor_step.sv
`default_nettype none
// ============================================================================
//  Module      : cursor_step
//  Description : Combinational next-position calculator for one cursor.
//                Right beats left, up beats down, up decreases y. Arithmetic
//                is one bit wider than the coordinate and the result is
//                clamped to the visible screen (no wrap-around).
//  Revision    : 1.0 - initial release
// ============================================================================
module cursor_step #(
  parameter int SCR_W = 160,
  parameter int SCR_H = 120,
  parameter int XW    = 8,
  parameter int YW    = 7,
  parameter int STEP  = 1
) (
  input  logic [XW-1:0] cur_x,
  input  logic [YW-1:0] cur_y,
  input  logic          left,
  input  logic          up,
  input  logic          down,
  input  logic          right,
  input  logic          fast,
  output logic [XW-1:0] nxt_x,
  output logic [YW-1:0] nxt_y
);

  localparam logic [XW:0] STEP_X1 = (XW+1)'(STEP);
  localparam logic [XW:0] STEP_X2 = (XW+1)'(2*STEP);
  localparam logic [XW:0] MAX_X   = (XW+1)'(SCR_W-1);
  localparam logic [YW:0] STEP_Y1 = (YW+1)'(STEP);
  localparam logic [YW:0] STEP_Y2 = (YW+1)'(2*STEP);
  localparam logic [YW:0] MAX_Y   = (YW+1)'(SCR_H-1);

  logic [XW:0] step_x;
  logic [XW:0] wide_x;
  logic [YW:0] step_y;
  logic [YW:0] wide_y;

  // Horizontal move: saturate at the right edge, floor at zero on the left
  always_comb begin
    step_x = fast ? STEP_X2 : STEP_X1;
    wide_x = {1'b0, cur_x};
    if (right) begin
      wide_x = wide_x + step_x;
      if (wide_x > MAX_X) wide_x = MAX_X;
    end else if (left) begin
      if (wide_x < step_x) wide_x = '0;
      else                 wide_x = wide_x - step_x;
    end
    nxt_x = wide_x[XW-1:0];
  end

  // Vertical move: up is towards row zero, down saturates at the bottom row
  always_comb begin
    step_y = fast ? STEP_Y2 : STEP_Y1;
    wide_y = {1'b0, cur_y};
    if (up) begin
      if (wide_y < step_y) wide_y = '0;
      else                 wide_y = wide_y - step_y;
    end else if (down) begin
      wide_y = wide_y + step_y;
      if (wide_y > MAX_Y) wide_y = MAX_Y;
    end
    nxt_y = wide_y[YW-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/cursor_ctrl_multi.sv
`default_nettype none
// ============================================================================
//  Module      : cursor_ctrl_multi
//  Description : Moves N_CUR independent cursors on a tick strobe. For each
//                cursor that moves, the old pixel is erased and the new one
//                drawn over a valid/ready plot bus; positions commit on the
//                DRAW transfer. A single cursor_step block is shared by all
//                cursors through an idx mux.
//  Options     : define CURSOR_ACCEL_EN to add a per-cursor hold counter that
//                doubles the step once a direction has been held HOLD_TICKS
//                processed ticks.
//  Revision    : 1.0 - initial release
// ============================================================================
module cursor_ctrl_multi
  import cursor_pkg::*;
#(
  parameter int         SCR_W      = 160,
  parameter int         SCR_H      = 120,
  parameter int         XW         = 8,
  parameter int         YW         = 7,
  parameter int         N_CUR      = 2,
  parameter int         STEP       = 1,
  parameter int         X0         = 80,
  parameter int         Y0         = 60,
  parameter int         HOLD_TICKS = 8,
  parameter logic [2:0] CUR_COLOUR = DEF_CUR_COLOUR,
  parameter logic [2:0] BG_COLOUR  = DEF_BG_COLOUR
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic [4*N_CUR-1:0]     btn_n,
  output logic [N_CUR*XW-1:0]    cur_x,
  output logic [N_CUR*YW-1:0]    cur_y,
  output logic                   busy,
  cursor_ctrl_multi_if.master    plot
);

  localparam int            IW       = (N_CUR > 1) ? $clog2(N_CUR) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_CUR-1);

  state_t         state;
  state_t         state_nx;
  logic [IW-1:0]  idx;
  logic [IW-1:0]  idx_nx;
  logic           tick_d;
  logic           tick_rise;
  logic [4*N_CUR-1:0] btn_q;
  logic [XW-1:0]  pos_x [N_CUR];
  logic [YW-1:0]  pos_y [N_CUR];
  logic [XW-1:0]  tgt_x;
  logic [YW-1:0]  tgt_y;
  logic           pv;
  logic [XW-1:0]  px;
  logic [YW-1:0]  py;
  logic [2:0]     pc;

  logic [XW-1:0]  sel_x;
  logic [YW-1:0]  sel_y;
  logic [3:0]     sel_btn;   // active-high pressed flags of cursor idx
  logic           sel_fast;
  logic [XW-1:0]  step_x;
  logic [YW-1:0]  step_y;
  logic           moved;
  logic           xfer;

  assign tick_rise = tick & ~tick_d;
  assign moved     = (step_x != sel_x) || (step_y != sel_y);
  assign xfer      = pv && plot.plot_ready;
  assign busy      = (state != IDLE);

  assign plot.plot_valid  = pv;
  assign plot.plot_x      = px;
  assign plot.plot_y      = py;
  assign plot.plot_colour = pc;

  // Select the current position and latched buttons of cursor idx
  always_comb begin
    sel_x   = pos_x[0];
    sel_y   = pos_y[0];
    sel_btn = ~btn_q[3:0];
    for (int i = 0; i < N_CUR; i++) begin
      if (idx == IW'(i)) begin
        sel_x   = pos_x[i];
        sel_y   = pos_y[i];
        sel_btn = ~btn_q[4*i +: 4];
      end
    end
  end

  cursor_step #(
    .SCR_W (SCR_W),
    .SCR_H (SCR_H),
    .XW    (XW),
    .YW    (YW),
    .STEP  (STEP)
  ) u_step (
    .cur_x (sel_x),
    .cur_y (sel_y),
    .left  (sel_btn[BTN_LEFT]),
    .up    (sel_btn[BTN_UP]),
    .down  (sel_btn[BTN_DOWN]),
    .right (sel_btn[BTN_RIGHT]),
    .fast  (sel_fast),
    .nxt_x (step_x),
    .nxt_y (step_y)
  );

`ifdef CURSOR_ACCEL_EN
  localparam int HW = $clog2(HOLD_TICKS+1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);

  logic [HW-1:0] hold_cnt [N_CUR];

  // Double step once the count reached the threshold before this move
  always_comb begin
    sel_fast = 1'b0;
    for (int i = 0; i < N_CUR; i++) begin
      if (idx == IW'(i)) sel_fast = (hold_cnt[i] >= HOLD_MAX);
    end
  end

  // Count processed ticks with any direction held, saturating; clear on release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CUR; i++) hold_cnt[i] <= '0;
    end else if (state == CALC) begin
      for (int i = 0; i < N_CUR; i++) begin
        if (idx == IW'(i)) begin
          if (|sel_btn) begin
            if (hold_cnt[i] != HOLD_MAX) hold_cnt[i] <= hold_cnt[i] + 1'b1;
          end else begin
            hold_cnt[i] <= '0;
          end
        end
      end
    end
  end
`else
  assign sel_fast = 1'b0;
`endif

  // State and cursor-index register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // Next-state logic; ticks outside IDLE are simply ignored
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      IDLE: begin
        if (tick_rise) begin
          state_nx = CALC;
          idx_nx   = '0;
        end
      end
      CALC:  state_nx = moved ? ERASE : NEXT;
      ERASE: if (xfer) state_nx = DRAW;
      DRAW:  if (xfer) state_nx = NEXT;
      NEXT: begin
        if (idx == LAST_IDX) begin
          state_nx = IDLE;
        end else begin
          idx_nx   = idx + 1'b1;
          state_nx = CALC;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: button latch, target capture, plot payload and position commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_d <= 1'b0;
      btn_q  <= '1;
      tgt_x  <= '0;
      tgt_y  <= '0;
      pv     <= 1'b0;
      px     <= '0;
      py     <= '0;
      pc     <= BG_COLOUR;
      for (int i = 0; i < N_CUR; i++) begin
        pos_x[i] <= XW'(X0);
        pos_y[i] <= YW'(Y0);
      end
    end else begin
      tick_d <= tick;
      case (state)
        IDLE: begin
          if (tick_rise) btn_q <= btn_n;
        end
        CALC: begin
          if (moved) begin
            tgt_x <= step_x;
            tgt_y <= step_y;
            px    <= sel_x;
            py    <= sel_y;
            pc    <= BG_COLOUR;
            pv    <= 1'b1;
          end
        end
        ERASE: begin
          if (xfer) begin
            px <= tgt_x;
            py <= tgt_y;
            pc <= CUR_COLOUR;
          end
        end
        DRAW: begin
          if (xfer) begin
            pv <= 1'b0;
            for (int i = 0; i < N_CUR; i++) begin
              if (idx == IW'(i)) begin
                pos_x[i] <= tgt_x;
                pos_y[i] <= tgt_y;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Flatten committed positions onto the output buses
  for (genvar g = 0; g < N_CUR; g++) begin : g_out
    assign cur_x[g*XW +: XW] = pos_x[g];
    assign cur_y[g*YW +: YW] = pos_y[g];
  end

endmodule
`default_nettype wire

// File: tb/tb_cursor_ctrl_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cursor_ctrl_multi
//  Description : Self-checking bench for cursor_ctrl_multi (default params).
//                Directed vector table, hand-written handshake sequences and
//                random ticks compared against a position-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cursor_ctrl_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic [7:0]  btn_n;
  logic [15:0] cur_x;
  logic [13:0] cur_y;
  logic        busy;

  cursor_ctrl_multi_if #(.XW(8), .YW(7)) plot_bus ();

  cursor_ctrl_multi dut (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .btn_n (btn_n),
    .cur_x (cur_x),
    .cur_y (cur_y),
    .busy  (busy),
    .plot  (plot_bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: per-cursor positions and hold counts, expected transfers
  int mx [2];
  int my [2];
  int mh [2];
  int exp_q [$];
  int got_q [$];

  typedef struct {
    logic [7:0] btn;
    int x0, y0, x1, y1, np;
  } vec_t;
  vec_t vecs [6];

  function automatic int pk(input int x, input int y, input int c);
    return (x << 10) | (y << 3) | c;
  endfunction

  function automatic int dut_payload();
    return int'({plot_bus.plot_x, plot_bus.plot_y, plot_bus.plot_colour});
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One processed tick: each cursor moves by +/-step, clamped to the screen
  task automatic model_tick(input logic [7:0] b);
    bit l, u, d, r;
    int st, nx, ny;
    for (int i = 0; i < 2; i++) begin
      l  = !b[4*i+3];
      u  = !b[4*i+2];
      d  = !b[4*i+1];
      r  = !b[4*i];
      st = 1;
`ifdef CURSOR_ACCEL_EN
      if (mh[i] >= 8) st = 2;
      if (l || u || d || r) mh[i] = (mh[i] < 8) ? mh[i] + 1 : 8;
      else                  mh[i] = 0;
`endif
      nx = mx[i] + (r ? st : (l ? -st : 0));
      ny = my[i] + (u ? -st : (d ? st : 0));
      if (nx < 0)   nx = 0;
      if (nx > 159) nx = 159;
      if (ny < 0)   ny = 0;
      if (ny > 119) ny = 119;
      if (nx != mx[i] || ny != my[i]) begin
        exp_q.push_back(pk(mx[i], my[i], 0));
        exp_q.push_back(pk(nx, ny, 4));
        mx[i] = nx;
        my[i] = ny;
      end
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick  = 1'b0;
    btn_n = 8'hFF;
    plot_bus.plot_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mx[i] = 80; my[i] = 60; mh[i] = 0;
    end
    exp_q.delete();
    @(negedge clk);
  endtask

  // Drive random ready while busy, record transfers, check payload holding
  task automatic collect(input int pct);
    int cyc = 0;
    int hold_bad = 0;
    bit pv = 0;
    bit pr = 0;
    int pp = 0;
    int cur;
    got_q.delete();
    while (busy && cyc < 200) begin
      plot_bus.plot_ready = ($urandom_range(99) < pct);
      cur = dut_payload();
      if (pv && !pr && (!plot_bus.plot_valid || cur != pp)) hold_bad++;
      if (plot_bus.plot_valid && plot_bus.plot_ready) got_q.push_back(cur);
      pv = plot_bus.plot_valid;
      pr = plot_bus.plot_ready;
      pp = cur;
      @(negedge clk);
      cyc++;
    end
    plot_bus.plot_ready = 1'b1;
    check("busy_timeout", int'(cyc < 200), 1);
    check("payload_hold", hold_bad, 0);
    check("xfer_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check("xfer_payload", got_q[i], exp_q[i]);
    exp_q.delete();
  endtask

  task automatic do_tick(input logic [7:0] b, input int pct);
    model_tick(b);
    btn_n = b;
    tick  = 1'b1;
    @(negedge clk);
    tick  = 1'b0;
    check("busy_after_tick", int'(busy), 1);
    collect(pct);
    check("pos0", int'({cur_x[7:0], cur_y[6:0]}), (mx[0] << 7) | my[0]);
    check("pos1", int'({cur_x[15:8], cur_y[13:7]}), (mx[1] << 7) | my[1]);
  endtask

  initial begin
    int extra;
    int guard;
    int p0;
    logic [7:0] rb;

    vecs[0] = '{8'b1111_1110, 81, 60, 80, 60, 2};
    vecs[1] = '{8'b1011_1111, 81, 60, 80, 59, 2};
    vecs[2] = '{8'b1111_0000, 82, 59, 80, 59, 2};
    vecs[3] = '{8'b1101_1101, 82, 60, 80, 60, 4};
    vecs[4] = '{8'b1111_1111, 82, 60, 80, 60, 0};
    vecs[5] = '{8'b0111_1111, 82, 60, 79, 60, 2};

    reset = 1'b1;
    tick  = 1'b0;
    btn_n = 8'hFF;
    plot_bus.plot_ready = 1'b1;

    // Reset state
    apply_reset();
    check("rst_x0", int'(cur_x[7:0]), 80);
    check("rst_y0", int'(cur_y[6:0]), 60);
    check("rst_x1", int'(cur_x[15:8]), 80);
    check("rst_y1", int'(cur_y[13:7]), 60);
    check("rst_valid", int'(plot_bus.plot_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_payload", dut_payload(), pk(0, 0, 0));

    // Cursor0 right: exact latency and payload sequence, cursor1 silent
    btn_n = 8'hFE;
    tick  = 1'b1;
    @(negedge clk);
    tick  = 1'b0;
    check("lat_calc_busy", int'(busy), 1);
    check("lat_calc_valid", int'(plot_bus.plot_valid), 0);
    @(negedge clk);
    check("lat_erase_valid", int'(plot_bus.plot_valid), 1);
    check("erase_payload", dut_payload(), pk(80, 60, 0));
    @(negedge clk);
    check("draw_valid", int'(plot_bus.plot_valid), 1);
    check("draw_payload", dut_payload(), pk(81, 60, 4));
    @(negedge clk);
    extra = 0;
    guard = 0;
    while (busy && guard < 20) begin
      if (plot_bus.plot_valid) extra++;
      @(negedge clk);
      guard++;
    end
    check("c1_no_plot", extra, 0);
    check("seq_idle", int'(busy), 0);
    check("seq_x0", int'(cur_x[7:0]), 81);
    check("seq_x1", int'(cur_x[15:8]), 80);

    // Vector table from home position
    apply_reset();
    foreach (vecs[k]) begin
      do_tick(vecs[k].btn, 60);
      check("vec_np", got_q.size(), vecs[k].np);
      check("vec_x0", int'(cur_x[7:0]),  vecs[k].x0);
      check("vec_y0", int'(cur_y[6:0]),  vecs[k].y0);
      check("vec_x1", int'(cur_x[15:8]), vecs[k].x1);
      check("vec_y1", int'(cur_y[13:7]), vecs[k].y1);
    end

    // Screen-edge clamping: no plot once at the edge
    apply_reset();
    guard = 0;
    while (mx[0] != 159 && guard < 200) begin
      do_tick(8'hFE, 100);
      guard++;
    end
    do_tick(8'hFE, 100);
    check("right_edge_np", got_q.size(), 0);
    check("right_edge_x", int'(cur_x[7:0]), 159);
    guard = 0;
    while (mx[1] != 0 && guard < 200) begin
      do_tick(8'h7F, 100);
      guard++;
    end
    do_tick(8'h7F, 100);
    check("left_edge_np", got_q.size(), 0);
    check("left_edge_x", int'(cur_x[15:8]), 0);

    // Backpressure in ERASE with a tick pulse that must be dropped
    apply_reset();
    model_tick(8'hFE);
    plot_bus.plot_ready = 1'b0;
    btn_n = 8'hFE;
    tick  = 1'b1;
    @(negedge clk);
    tick  = 1'b0;
    guard = 0;
    while (!plot_bus.plot_valid && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    p0 = dut_payload();
    check("bp_erase_payload", p0, pk(80, 60, 0));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 1) tick = 1'b1;
      if (k == 3) tick = 1'b0;
      check("bp_hold", int'(plot_bus.plot_valid && dut_payload() == p0), 1);
    end
    collect(100);
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy || plot_bus.plot_valid) extra++;
    end
    check("bp_tick_dropped", extra, 0);
    check("bp_x0", int'(cur_x[7:0]), 81);

    // Reset in the middle of a stalled transfer
    apply_reset();
    plot_bus.plot_ready = 1'b0;
    btn_n = 8'hFE;
    tick  = 1'b1;
    @(negedge clk);
    tick  = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", int'(plot_bus.plot_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_x0", int'(cur_x[7:0]), 80);
    apply_reset();

    // Random buttons and random backpressure
    for (int k = 0; k < 40; k++) begin
      rb = 8'($urandom);
      do_tick(rb, $urandom_range(30, 100));
    end

`ifdef CURSOR_ACCEL_EN
    // Held direction accelerates after HOLD_TICKS processed ticks
    apply_reset();
    for (int t = 1; t <= 10; t++) begin
      do_tick(8'hFE, 100);
      if (t == 8)  check("accel_t8", int'(cur_x[7:0]), 88);
      if (t == 9)  check("accel_t9", int'(cur_x[7:0]), 90);
      if (t == 10) check("accel_t10", int'(cur_x[7:0]), 92);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cursor_ctrl_multi.md
CURSOR_CTRL_MULTI -- requirements
Module: cursor_ctrl_multi

Interface
REQ-001 SHALL have parameter SCR_W, default 160, screen width in pixels.
REQ-002 SHALL have parameter SCR_H, default 120, screen height in pixels.
REQ-003 SHALL have parameter XW, default 8, and parameter YW, default 7, the x and y coordinate widths.
REQ-004 SHALL have parameter N_CUR, default 2, the number of independent cursors.
REQ-005 SHALL have parameters STEP, default 1, pixels per move; X0, default 80, and Y0, default 60, the home position; HOLD_TICKS, default 8, the acceleration threshold.
REQ-006 SHALL have parameter CUR_COLOUR, default 3'b100, and parameter BG_COLOUR, default 3'b000.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all flops rise-edge.
REQ-008 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port tick, input, 1 bit: frame/update strobe; level input, rising edge detected internally.
REQ-010 SHALL have port btn_n, input, 4*N_CUR bits, active-low; per cursor i: [4i+3] left, [4i+2] up, [4i+1] down, [4i] right.
REQ-011 SHALL have ports cur_x, output, N_CUR*XW bits, and cur_y, output, N_CUR*YW bits: committed positions.
REQ-012 SHALL have plot outputs plot_valid (1 bit), plot_x (XW bits), plot_y (YW bits), plot_colour (3 bits), and input plot_ready (1 bit).
REQ-013 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, CALC, ERASE, DRAW and NEXT; index idx selects the cursor.
REQ-015 In IDLE, a tick rising edge SHALL latch btn_n, set idx to 0 and enter CALC on the next cycle.
REQ-016 CALC SHALL compute the target position in one cycle: right beats left, up beats down, y decreases for up.
REQ-017 Arithmetic SHALL use XW+1 / YW+1 bits; results SHALL clamp to [0, SCR_W-1] x [0, SCR_H-1]; no wrap-around.
REQ-018 If the target differs from the current position, CALC SHALL go to ERASE; otherwise it SHALL go to NEXT.
REQ-019 ERASE SHALL present the old position with BG_COLOUR; DRAW SHALL present the target position with CUR_COLOUR.
REQ-020 A transfer SHALL occur on a clk edge with plot_valid && plot_ready; the payload SHALL be held stable until then.
REQ-021 The cursor position SHALL update in the same edge as the DRAW transfer; ERASE -> DRAW -> NEXT.
REQ-022 NEXT SHALL increment idx and enter CALC, or enter IDLE after cursor N_CUR-1.
REQ-023 plot_valid SHALL first assert 2 cycles after the tick edge is sampled, with plot_ready high throughout.
REQ-024 Tick edges while busy SHALL be dropped, with no queueing.

Reset
REQ-025 On reset, all cursors SHALL go to (X0, Y0), state to IDLE, and idx, plot_valid and busy to 0.
REQ-026 On reset, plot_x and plot_y SHALL go to 0, plot_colour to BG_COLOUR, and the tick-edge register to 0.
REQ-027 Reset asserted mid-handshake SHALL abandon the transfer, with plot_valid low immediately; no position changes.

Configuration
REQ-028 Macro CURSOR_ACCEL_EN SHALL compile in a per-cursor hold counter that saturates at HOLD_TICKS.
REQ-029 With CURSOR_ACCEL_EN, the counter SHALL increment on each processed tick with any direction pressed and clear when none is pressed.
REQ-030 With CURSOR_ACCEL_EN, the step SHALL be 2*STEP when the counter was >= HOLD_TICKS before the move.
REQ-031 Without CURSOR_ACCEL_EN, the step SHALL always be STEP and no counter logic SHALL exist.

Structure
REQ-032 Package cursor_pkg SHALL hold the state enum, the button bit indices (LEFT=3, UP=2, DOWN=1, RIGHT=0), and the default colour constants.
REQ-033 Combinational next-position and clamp logic SHALL live in sub-module cursor_step, instantiated once and muxed by idx.

Verification
REQ-034 Scenario: reset, then release -> all cursors at (80,60), plot_valid=0, busy=0.
REQ-035 Scenario: cursor0 right, plot_ready=1, one tick -> transfers (80,60,000) then (81,60,100); cur_x[0]=81; cursor1 unchanged with no plot.
REQ-036 Scenario: cursor at x=159 pressing right, and at x=0 pressing left -> no plot transfer; positions stay 159 and 0.
REQ-037 Scenario: left+right and up+down pressed from (80,60) -> commits (81,59).
REQ-038 Scenario: plot_ready low for 5 cycles in ERASE, plus a tick pulse meanwhile -> payload stable, plot_valid held, extra tick ignored.
REQ-039 Scenario (CURSOR_ACCEL_EN, HOLD_TICKS=8): right held for 10 ticks from x=80 -> x=88 after tick 8, 90 after tick 9, 92 after tick 10.
